// File: rtl/mul_seq_param_if.sv
// Operand/result bundle for the sequential multiplier: serial operand bus,
// start/mode controls and the busy/done/result status returned by the core.
interface mul_seq_param_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic               sgn;
  logic [WIDTH-1:0]   data_in;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, sgn, data_in,
    input  busy, done, result
  );

  modport slave (
    input  start, sgn, data_in,
    output busy, done, result
  );
endinterface

// File: rtl/mul_seq_param.sv
// Parametrised shift-and-add multiplier with serial operand loading (A then B),
// signed/unsigned mode and early termination once the remaining multiplier is zero.
module mul_seq_param #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  mul_seq_param_if.slave    bus
);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CALC,
    DONE
  } state_t;

  state_t           state_reg,  state_next;
  logic [WIDTH-1:0] a_raw_reg,  a_raw_next;
  logic [PW-1:0]    ma_reg,     ma_next;
  logic [WIDTH-1:0] mb_reg,     mb_next;
  logic             neg_reg,    neg_next;
  logic [PW-1:0]    p_reg,      p_next;
  logic [PW-1:0]    result_reg, result_next;

  // Unsigned magnitude in WIDTH bits; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? ((~x) + WIDTH'(1)) : x;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_raw_reg  <= '0;
      ma_reg     <= '0;
      mb_reg     <= '0;
      neg_reg    <= 1'b0;
      p_reg      <= '0;
      result_reg <= '0;
    end else begin
      a_raw_reg  <= a_raw_next;
      ma_reg     <= ma_next;
      mb_reg     <= mb_next;
      neg_reg    <= neg_next;
      p_reg      <= p_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_raw_next  = a_raw_reg;
    ma_next     = ma_reg;
    mb_next     = mb_reg;
    neg_next    = neg_reg;
    p_next      = p_reg;
    result_next = result_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.start) state_next = LOAD_A;
      end

      // A is kept raw so that it is interpreted with the mode seen alongside B.
      LOAD_A: begin
        a_raw_next = bus.data_in;
        state_next = LOAD_B;
      end

      LOAD_B: begin
        ma_next    = {{WIDTH{1'b0}}, magnitude(a_raw_reg, bus.sgn)};
        mb_next    = magnitude(bus.data_in, bus.sgn);
        neg_next   = bus.sgn & (a_raw_reg[WIDTH-1] ^ bus.data_in[WIDTH-1]);
        p_next     = '0;
        state_next = CALC;
      end

      // Stops as soon as the multiplier is exhausted; negating a zero sum stays zero.
      CALC: begin
        if (mb_reg == '0) begin
          result_next = neg_reg ? ((~p_reg) + PW'(1)) : p_reg;
          state_next  = DONE;
        end else begin
          if (mb_reg[0]) p_next = p_reg + ma_reg;
          ma_next = ma_reg << 1;
          mb_next = mb_reg >> 1;
        end
      end

      DONE: begin
        if (bus.start) state_next = LOAD_A;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.busy   = (state_reg == LOAD_A) || (state_reg == LOAD_B) || (state_reg == CALC);
  assign bus.done   = (state_reg == DONE);
  assign bus.result = result_reg;
endmodule

// File: tb/tb_mul_seq_param.sv
// Bench for mul_seq_param: directed vector table, random operands against an
// arithmetic reference, held-start back-to-back and asynchronous mid-CALC reset.
module tb_mul_seq_param;
  localparam int W = 16;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  mul_seq_param_if #(.WIDTH(W)) bus ();

  mul_seq_param #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] exp;
    int             lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer multiplication in the selected interpretation.
  function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic s);
    longint x;
    longint y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return (2*W)'(x * y);
  endfunction

  // Expected done latency: 3 + number of significant bits of |B|.
  function automatic int model_lat(input logic [W-1:0] b, input logic s);
    longint m;
    int     n;
    m = s ? longint'($signed(b)) : longint'(b);
    if (m < 0) m = -m;
    n = 0;
    while (m > 0) begin
      m = m / 2;
      n++;
    end
    return 3 + n;
  endfunction

  task automatic wait_done(inout int lat);
    bit seen;
    bit busy_ok;
    seen    = 1'b0;
    busy_ok = 1'b1;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else if (!bus.busy) busy_ok = 1'b0;
    end
    check("done_timeout", 64'(seen), 64'd1);
    check("busy_during_op", 64'(busy_ok), 64'd1);
    check("busy_low_at_done", 64'(bus.busy), 64'd0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit hold, output logic [2*W-1:0] res, output int lat);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.sgn     = s;
    bus.data_in = a;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.data_in = b;
    @(posedge clk);
    lat = 2;
    wait_done(lat);
    res = bus.result;
    $display("[TB] op a=0x%04h b=0x%04h sgn=%0d -> result=0x%08h latency=%0d", a, b, s, res, lat);
  endtask

  initial begin
    logic [2*W-1:0] res;
    int             lat;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic           rs;

    tests = 0;
    fails = 0;

    vecs[0] = '{16'h001E, 16'h0005, 1'b0, 32'h0000_0096, 6};
    vecs[1] = '{16'hFFFD, 16'h0007, 1'b1, 32'hFFFF_FFEB, 6};
    vecs[2] = '{16'h0007, 16'hFFFD, 1'b1, 32'hFFFF_FFEB, 5};
    vecs[3] = '{16'h1234, 16'h0000, 1'b0, 32'h0000_0000, 3};
    vecs[4] = '{16'h1234, 16'h0000, 1'b1, 32'h0000_0000, 3};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 19};
    vecs[6] = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 19};
    vecs[7] = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000, 4};
    vecs[8] = '{16'h0000, 16'hFFFF, 1'b1, 32'h0000_0000, 4};
    vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 4};

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.sgn     = 1'b0;
    bus.data_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_result", 64'(bus.result), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, res, lat);
      check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, 1'b0, res, lat);
      check($sformatf("rand%0d_result", i), 64'(res), 64'(model_prod(ra, rb, rs)));
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'(model_lat(rb, rs)));
    end

    // start held through an entire operation, then a back-to-back second one
    run_op(16'd5, 16'd6, 1'b0, 1'b1, res, lat);
    check("held_result", 64'(res), 64'd30);
    check("held_latency", 64'(lat), 64'd6);
    bus.data_in = 16'd2;
    bus.sgn     = 1'b0;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    check("b2b_done_low", 64'(bus.done), 64'd0);
    check("b2b_busy_high", 64'(bus.busy), 64'd1);
    check("b2b_result_held", 64'(bus.result), 64'd30);
    bus.start = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.data_in = 16'd3;
    @(posedge clk);
    lat = 2;
    wait_done(lat);
    $display("[TB] op a=0x0002 b=0x0003 sgn=0 (back-to-back) -> result=0x%08h latency=%0d",
             bus.result, lat);
    check("b2b_result", 64'(bus.result), 64'd6);
    check("b2b_latency", 64'(lat), 64'd5);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.data_in = 16'hFFFF;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_done", 64'(bus.done), 64'd0);
    check("async_rst_result", 64'(bus.result), 64'd0);
    $display("[TB] async reset asserted mid-CALC");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_after_rst_busy", 64'(bus.busy), 64'd0);
    check("idle_after_rst_done", 64'(bus.done), 64'd0);
    run_op(16'd9, 16'd9, 1'b0, 1'b0, res, lat);
    check("post_rst_result", 64'(res), 64'd81);
    check("post_rst_latency", 64'(lat), 64'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
